// File: rtl/aes_round_sequencer_if.sv
// Block-stream and round-datapath signals of the iterative AES-128 sequencer.
// The slave modport is the sequencer's view; master is the producer/consumer/datapath side.
interface aes_round_sequencer_if #(
    parameter int DW = 128
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] plain;
    logic [DW-1:0] key;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] cipher;
    logic          busy;
    logic [3:0]    rd_round;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] rd_key;
    logic [DW-1:0] rd_key_nxt;
    logic [DW-1:0] rd_full_out;
    logic [DW-1:0] rd_final_out;

    modport slave (
        input  in_valid, plain, key, out_ready, rd_key_nxt, rd_full_out, rd_final_out,
        output in_ready, out_valid, cipher, busy, rd_round, rd_data, rd_key
    );

    modport master (
        output in_valid, plain, key, out_ready, rd_key_nxt, rd_full_out, rd_final_out,
        input  in_ready, out_valid, cipher, busy, rd_round, rd_data, rd_key
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 controller: walks one shared round datapath through the rounds,
// holding state, round key and round counter between the block-level valid/ready streams.
module aes_round_sequencer #(
    parameter int NUM_ROUNDS = 10,
    parameter int DW         = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    aes_round_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } fsm_t;

    localparam logic [3:0] LAST_RC = 4'(NUM_ROUNDS);

    fsm_t          fsm_q, fsm_d;
    logic [DW-1:0] state_q, state_d;
    logic [DW-1:0] key_q, key_d;
    logic [3:0]    rc_q, rc_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic          in_ready;
    logic          accept;

    // Ready is combinational so a stalled DONE can hand over to the next block without a bubble.
    assign in_ready = (fsm_q == S_IDLE) | ((fsm_q == S_DONE) & bus.out_ready);
    assign accept   = bus.in_valid & in_ready;

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        key_d       = key_q;
        rc_d        = rc_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (fsm_q)
            S_IDLE: begin
                if (accept) begin
                    state_d     = bus.plain ^ bus.key;
                    key_d       = bus.key;
                    rc_d        = 4'd1;
                    fsm_d       = S_ROUND;
                    busy_d      = 1'b1;
                    out_valid_d = 1'b0;
                end
            end
            S_ROUND: begin
                state_d = bus.rd_full_out;
                key_d   = bus.rd_key_nxt;
                rc_d    = rc_q + 4'd1;
                if (rc_q + 4'd1 == LAST_RC) begin
                    fsm_d = S_FINAL;
                end
            end
            S_FINAL: begin
                state_d     = bus.rd_final_out;
                key_d       = bus.rd_key_nxt;
                rc_d        = 4'd0;
                fsm_d       = S_DONE;
                out_valid_d = 1'b1;
                busy_d      = 1'b0;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (bus.in_valid) begin
                        state_d = bus.plain ^ bus.key;
                        key_d   = bus.key;
                        rc_d    = 4'd1;
                        fsm_d   = S_ROUND;
                        busy_d  = 1'b1;
                    end else begin
                        fsm_d = S_IDLE;
                    end
                end
            end
            default: begin
                fsm_d       = S_IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fsm_q       <= S_IDLE;
            state_q     <= '0;
            key_q       <= '0;
            rc_q        <= 4'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            key_q       <= key_d;
            rc_q        <= rc_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.cipher    = state_q;
    assign bus.busy      = busy_q;
    assign bus.rd_round  = rc_q;
    assign bus.rd_data   = state_q;
    assign bus.rd_key    = key_q;
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: a behavioural AES round datapath closes the loop and
// directed FIPS-197 vectors are checked against their published ciphertexts.
module tb_aes_round_sequencer;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   lat;
    int   n;
    int   viol;
    logic [127:0] kn;

    always #5 clk = ~clk;

    aes_round_sequencer_if #(.DW(128)) ifc ();

    aes_round_sequencer #(.NUM_ROUNDS(10), .DW(128)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (ifc.slave)
    );

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    // Inverse as x^254 by square-and-multiply, then the FIPS-197 affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        logic [7:0] p = x;
        logic [7:0] b;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        b = r;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [3:0] rnd);
        logic [7:0]  rc = 8'h01;
        logic [31:0] t, n0, n1, n2, n3;
        for (int i = 1; i < int'(rnd); i++) rc = xt(rc);
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    always_comb begin
        kn               = key_exp(ifc.rd_key, ifc.rd_round);
        ifc.rd_key_nxt   = kn;
        ifc.rd_full_out  = mix_cols(shift_rows(sub_bytes(ifc.rd_data))) ^ kn;
        ifc.rd_final_out = shift_rows(sub_bytes(ifc.rd_data)) ^ kn;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic offer(input logic [127:0] pt, input logic [127:0] k);
        ifc.plain    = pt;
        ifc.key      = k;
        ifc.in_valid = 1'b1;
    endtask

    // Called on the first falling edge after the accepting edge; lat counts edges since accept.
    task automatic wait_done(output int l, input bit seq);
        l = 0;
        while (!ifc.out_valid && l < 40) begin
            if (seq) chk($sformatf("t2_round_%0d", l + 1), 128'(ifc.rd_round), 128'(l + 1));
            @(negedge clk);
            l++;
        end
    endtask

    task automatic consume(input string tag);
        ifc.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.out_ready = 1'b0;
        chk({tag, "_ov_clr"}, 128'(ifc.out_valid), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b0;
        ifc.plain     = '0;
        ifc.key       = '0;
        repeat (2) @(negedge clk);
        chk("rst_ov", 128'(ifc.out_valid), 128'(0));
        chk("rst_busy", 128'(ifc.busy), 128'(0));
        chk("rst_round", 128'(ifc.rd_round), 128'(0));
        chk("rst_ct", ifc.cipher, 128'(0));
        chk("rst_in_ready", 128'(ifc.in_ready), 128'(1));
        rst_n = 1'b1;
        @(negedge clk);

        // Vector 1 with latency
        offer(P1, K1);
        chk("t1_in_ready", 128'(ifc.in_ready), 128'(1));
        @(posedge clk);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        chk("t1_busy", 128'(ifc.busy), 128'(1));
        chk("t1_in_ready_busy", 128'(ifc.in_ready), 128'(0));
        wait_done(lat, 1'b0);
        chk("t1_lat", 128'(lat), 128'(10));
        chk("t1_ct", ifc.cipher, C1);
        chk("t1_busy_done", 128'(ifc.busy), 128'(0));
        chk("t1_in_ready_done", 128'(ifc.in_ready), 128'(0));
        consume("t1");

        // Vector 2 with round-number sequence
        offer(P2, K2);
        @(posedge clk);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        wait_done(lat, 1'b1);
        chk("t2_lat", 128'(lat), 128'(10));
        chk("t2_ct", ifc.cipher, C2);
        chk("t2_round_done", 128'(ifc.rd_round), 128'(0));
        consume("t2");

        // Backpressure for 20 cycles with a competing offer
        offer(P1, K1);
        @(posedge clk);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        wait_done(lat, 1'b0);
        chk("t4_ct", ifc.cipher, C1);
        offer(P2, K2);
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (!ifc.out_valid || ifc.cipher !== C1 || ifc.in_ready || ifc.busy) viol++;
        end
        chk("t4_stall", 128'(viol), 128'(0));
        ifc.in_valid = 1'b0;
        consume("t4");
        chk("t4_idle_busy", 128'(ifc.busy), 128'(0));
        chk("t4_idle_round", 128'(ifc.rd_round), 128'(0));

        // Back-to-back blocks with consumer always ready
        ifc.out_ready = 1'b1;
        offer(P1, K1);
        @(posedge clk);
        @(negedge clk);
        ifc.plain = P2;
        ifc.key   = K2;
        wait_done(lat, 1'b0);
        chk("t3_lat1", 128'(lat), 128'(10));
        chk("t3_ct1", ifc.cipher, C1);
        chk("t3_in_ready_done", 128'(ifc.in_ready), 128'(1));
        @(posedge clk);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        chk("t3_busy2", 128'(ifc.busy), 128'(1));
        chk("t3_round2", 128'(ifc.rd_round), 128'(1));
        chk("t3_ov_gap", 128'(ifc.out_valid), 128'(0));
        wait_done(lat, 1'b0);
        chk("t3_lat2", 128'(lat), 128'(10));
        chk("t3_ct2", ifc.cipher, C2);
        @(posedge clk);
        @(negedge clk);
        chk("t3_idle_ov", 128'(ifc.out_valid), 128'(0));
        chk("t3_idle_busy", 128'(ifc.busy), 128'(0));
        ifc.out_ready = 1'b0;

        // Offer pulsed mid-block is ignored
        offer(P2, K2);
        @(posedge clk);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        n = 0;
        while (ifc.rd_round != 4'd5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reach_rc5", 128'(ifc.rd_round), 128'(5));
        offer(P1, K1);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        chk("t5_rc6", 128'(ifc.rd_round), 128'(6));
        wait_done(lat, 1'b0);
        chk("t5_ov", 128'(ifc.out_valid), 128'(1));
        chk("t5_ct", ifc.cipher, C2);
        consume("t5");

        // Reset mid-block, then a clean block
        offer(P1, K1);
        @(posedge clk);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        n = 0;
        while (ifc.rd_round != 4'd6 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reach_rc6", 128'(ifc.rd_round), 128'(6));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ov", 128'(ifc.out_valid), 128'(0));
        chk("t6_rst_round", 128'(ifc.rd_round), 128'(0));
        chk("t6_rst_busy", 128'(ifc.busy), 128'(0));
        chk("t6_rst_in_ready", 128'(ifc.in_ready), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        offer(P2, K2);
        @(posedge clk);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        wait_done(lat, 1'b0);
        chk("t6_lat", 128'(lat), 128'(10));
        chk("t6_ct", ifc.cipher, C2);
        consume("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
